// File: rtl/and_gate.sv
// Registered bitwise AND with a valid qualifier and all-ones / any-one reduction flags.
// One-cycle latency, one sample per cycle, no backpressure.
module and_gate #(
    parameter int unsigned WIDTH     = 1,
    parameter bit          RESET_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_all,
    output logic             out_any
);

    localparam logic [WIDTH-1:0] RESET_VEC = {WIDTH{RESET_OUT}};

    logic [WIDTH-1:0] and_c;

    // Operand AND ahead of the output register.
    always_comb begin
        and_c = in1 & in2;
    end

    // Valid pulses for one cycle per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result and reduction flags load only on acceptance; the reset flags track the reset value of out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= RESET_VEC;
            out_all <= RESET_OUT;
            out_any <= RESET_OUT;
        end else if (in_valid) begin
            out     <= and_c;
            out_all <= &and_c;
            out_any <= |and_c;
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: four instances (1-bit, 8-bit reset-to-zero,
// 8-bit reset-to-ones, 16-bit) share stimulus and are compared against a behavioural model.
module tb_and_gate;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in1;
    logic [63:0] in2;

    logic        o1;
    logic [7:0]  o8;
    logic [7:0]  o8r;
    logic [15:0] o16;
    logic        v_q [4];
    logic        all_q [4];
    logic        any_q [4];
    logic [63:0] out_q [4];

    int          n_checks;
    int          n_fail;

    // Model: per instance, the value of the last accepted AND and whether the last edge accepted.
    int unsigned w_of [4] = '{1, 8, 8, 16};
    bit          r_of [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] m_out [4];
    bit          m_valid [4];

    and_gate #(.WIDTH(1), .RESET_OUT(1'b0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1[0:0]), .in2(in2[0:0]),
        .out_valid(v_q[0]), .out(o1), .out_all(all_q[0]), .out_any(any_q[0]));

    and_gate #(.WIDTH(8), .RESET_OUT(1'b0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1[7:0]), .in2(in2[7:0]),
        .out_valid(v_q[1]), .out(o8), .out_all(all_q[1]), .out_any(any_q[1]));

    and_gate #(.WIDTH(8), .RESET_OUT(1'b1)) u_w8r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1[7:0]), .in2(in2[7:0]),
        .out_valid(v_q[2]), .out(o8r), .out_all(all_q[2]), .out_any(any_q[2]));

    and_gate #(.WIDTH(16), .RESET_OUT(1'b0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1[15:0]), .in2(in2[15:0]),
        .out_valid(v_q[3]), .out(o16), .out_all(all_q[3]), .out_any(any_q[3]));

    assign out_q[0] = 64'(o1);
    assign out_q[1] = 64'(o8);
    assign out_q[2] = 64'(o8r);
    assign out_q[3] = 64'(o16);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mask_of(int unsigned w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_out[i]   = r_of[i] ? mask_of(w_of[i]) : 64'd0;
            m_valid[i] = 1'b0;
        end
    endtask

    // What a rising edge must do given the inputs present at that edge.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] = in_valid;
                if (in_valid) m_out[i] = in1 & in2 & mask_of(w_of[i]);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] mk;
        for (int i = 0; i < 4; i++) begin
            mk = mask_of(w_of[i]);
            chk($sformatf("%s dut%0d out", tag, i), out_q[i], m_out[i]);
            chk($sformatf("%s dut%0d valid", tag, i), 64'(v_q[i]), 64'(m_valid[i]));
            chk($sformatf("%s dut%0d all", tag, i), 64'(all_q[i]), 64'(m_out[i] == mk));
            chk($sformatf("%s dut%0d any", tag, i), 64'(any_q[i]), 64'(m_out[i] != 64'd0));
        end
    endtask

    // One clock: model follows the edge, then all outputs are compared on the falling edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in1      = 64'd0;
        in2      = 64'd0;
        model_reset();

        cyc("reset");
        cyc("reset");
        chk("reset w8 out", out_q[1], 64'h00);
        chk("reset w8r out", out_q[2], 64'hFF);
        chk("reset w8r all", 64'(all_q[2]), 64'd1);
        chk("reset w8r any", 64'(any_q[2]), 64'd1);
        chk("reset w8 valid", 64'(v_q[1]), 64'd0);

        rst_n = 1'b1;

        // 1-bit truth table, back to back.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in1      = 64'(k >> 1);
            in2      = 64'(k & 1);
            cyc("truth");
            chk($sformatf("truth w1 out k=%0d", k), out_q[0], (k == 3) ? 64'd1 : 64'd0);
            chk($sformatf("truth w1 valid k=%0d", k), 64'(v_q[0]), 64'd1);
        end

        in1 = 64'hF0; in2 = 64'h3C;
        cyc("w8a");
        chk("w8a out", out_q[1], 64'h30);
        chk("w8a all", 64'(all_q[1]), 64'd0);
        chk("w8a any", 64'(any_q[1]), 64'd1);
        in1 = 64'hFF; in2 = 64'hFF;
        cyc("w8b");
        chk("w8b out", out_q[1], 64'hFF);
        chk("w8b all", 64'(all_q[1]), 64'd1);

        // Hold while idle, including unknown operands.
        in1 = 64'hA5; in2 = 64'hFF;
        cyc("hold0");
        in_valid = 1'b0;
        in1      = 64'h00;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                in1 = 'x;
                in2 = 'x;
            end
            cyc("hold");
            chk($sformatf("hold w8 out k=%0d", k), out_q[1], 64'hA5);
            chk($sformatf("hold w8 valid k=%0d", k), 64'(v_q[1]), 64'd0);
        end

        // Asynchronous reset between edges.
        in_valid = 1'b1; in1 = 64'hFF; in2 = 64'hFF;
        cyc("preasync");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async");
        chk("async w8 out", out_q[1], 64'h00);
        chk("async w8 any", 64'(any_q[1]), 64'd0);
        chk("async w8r out", out_q[2], 64'hFF);
        chk("async w8r all", 64'(all_q[2]), 64'd1);

        // Reset wins over a sample on the same edge.
        in_valid = 1'b1; in1 = 64'hFF; in2 = 64'hFF;
        cyc("collide");
        chk("collide w8 out", out_q[1], 64'h00);
        chk("collide w8 valid", 64'(v_q[1]), 64'd0);
        rst_n = 1'b1;
        in1 = 64'h0F; in2 = 64'h3F;
        cyc("postrst");
        chk("postrst w8 out", out_q[1], 64'h0F);
        chk("postrst w8 valid", 64'(v_q[1]), 64'd1);

        // Randomised traffic, occasionally all-ones operands to exercise out_all.
        for (int k = 0; k < 1000; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in1      = {$urandom(), $urandom()};
            in2      = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) begin
                in1 = {64{1'b1}};
                in2 = {64{1'b1}};
            end
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
